// File: rtl/pc_fetch.sv
// pc_fetch: program-counter register and instruction-fetch sequencer.
// It holds the architectural PC and fetches the word at that PC over a
// req/ack memory port. The instruction then goes to decode with a
// valid/ready handshake, and the next-PC result is loaded on each accept.
// Optional feature macro: PC_FETCH_MISALIGN_TRAP_EN (sticky misaligned-PC
// fault). When the macro is undefined, pc[1:0] is ignored for addressing.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic misaligned_pc;
    logic take_inst;
    logic accept;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    assign misaligned_pc = (pc[1:0] != 2'b00);
`else
    assign misaligned_pc = 1'b0;
`endif

    // A fetch completes only while a request is actually being issued.
    assign take_inst = (state == REQ) && !misaligned_pc && imem_ack;
    assign accept    = (state == VALID) && inst_ready;

    // The address always points at the word that contains pc.
    assign imem_addr = {pc[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (misaligned_pc) begin
                    state_nxt = FAULT;
                end else if (imem_ack) begin
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (inst_ready) begin
                    state_nxt = REQ;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = REQ;
        endcase
    end

    // Output decode from state and pc only. rst_n gates the request so
    // that it drops at the same moment reset is asserted.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        misalign   = 1'b0;
        case (state)
            REQ:     imem_req   = rst_n && !misaligned_pc;
            VALID:   inst_valid = 1'b1;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            FAULT:   misalign   = 1'b1;
`endif
            default: ;
        endcase
    end

    // PC and accepted-instruction counter advance on each decode accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else if (accept) begin
            pc          <= npc;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // Capture the returned instruction word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= '0;
        end else if (take_inst) begin
            inst <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch with RESET_PC = 32'h0000_1000.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = '0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        misalign;
    logic [31:0] fetch_count;

    int unsigned tests = 0;
    int unsigned fails = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .misalign   (misalign),
        .fetch_count(fetch_count)
    );

    // Reference model: a fetched-but-unconsumed word, a PC, a counter and a fault flag
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_count;
    bit          m_have;
    bit          m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_inst = '0; m_count = '0; m_have = 0; m_fault = 0;
        end else if (m_fault) begin
            m_fault = 1;
        end else if (!m_have) begin
            if (TRAP && m_pc[1:0] != 2'b00) m_fault = 1;
            else if (imem_ack) begin m_inst = imem_rdata; m_have = 1; end
        end else if (inst_ready) begin
            m_pc = npc; m_count = m_count + 1; m_have = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_req;
            exp_req = rst_n && !m_have && !m_fault && !(TRAP && m_pc[1:0] != 2'b00);
            chk("pc", pc, m_pc);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, m_pc & ~32'd3);
            chk("inst", inst, m_inst);
            chk("inst_valid", 32'(inst_valid), 32'(m_have));
            chk("misalign", 32'(misalign), 32'(m_fault));
            chk("fetch_count", fetch_count, m_count);
        end
    end

    // Apply inputs just after the falling edge, then run to the next falling edge
    task automatic cyc(input logic a, input logic [31:0] d, input logic r, input logic [31:0] n);
        #1;
        imem_ack = a; imem_rdata = d; inst_ready = r; npc = n;
        @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0000_1000);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0000_1000);
        chk_en = 1'b1;

        // Zero-wait memory, four back-to-back instructions
        for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b1, m_pc + 32'd4);
        chk("zw_pc", pc, 32'h0000_1010);
        chk("zw_count", fetch_count, 32'd4);

        // Ack delayed three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, $urandom, 1'b1, $urandom);
            chk("dly_req", 32'(imem_req), 32'd1);
            chk("dly_addr", imem_addr, 32'h0000_1010);
        end
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, $urandom);
        chk("dly_inst", inst, 32'hDEAD_BEEF);
        chk("dly_valid", 32'(inst_valid), 32'd1);

        // Backpressure while npc and stray acks change
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom), $urandom, 1'b0, $urandom);
            chk("bp_pc", pc, 32'h0000_1010);
            chk("bp_inst", inst, 32'hDEAD_BEEF);
            chk("bp_req", 32'(imem_req), 32'd0);
            chk("bp_count", fetch_count, 32'd4);
        end

        // Misaligned next PC accepted
        cyc(1'b0, $urandom, 1'b1, 32'h0000_2002);
        chk("mis_pc", pc, 32'h0000_2002);
        chk("mis_count", fetch_count, 32'd5);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        cyc(1'b1, $urandom, 1'b1, $urandom);
        cyc(1'b1, $urandom, 1'b1, $urandom);
        chk("mis_fault", 32'(misalign), 32'd1);
        chk("mis_req", 32'(imem_req), 32'd0);
        chk("mis_hold_pc", pc, 32'h0000_2002);
`else
        chk("mis_addr", imem_addr, 32'h0000_2000);
        chk("mis_req", 32'(imem_req), 32'd1);
        cyc(1'b1, 32'h1234_5678, 1'b0, $urandom);
        chk("mis_inst", inst, 32'h1234_5678);
`endif

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] n;
            n = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            cyc(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) != 0), n);
        end

        // Reach a waiting request (bounded), then reset mid-request
        for (int i = 0; i < 10 && m_have; i++) cyc(1'b0, $urandom, 1'b1, m_pc + 32'd4);
        chk("pre_rst_valid", 32'(inst_valid), 32'd0);
        #1;
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = $urandom;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        imem_ack = 1'b0;
        #1;
        chk("post_rst_pc", pc, 32'h0000_1000);
        chk("post_rst_count", fetch_count, 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 40; i++) cyc(1'($urandom), $urandom, 1'($urandom), m_pc + 32'd4);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
